// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: active-low glyphs,
// controller state encodings and the double-dabble helper.
package seg_pkg;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int BCD_ITER   = 16;
    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    // Add-3 correction applied to every BCD nibble before each shift.
    function automatic logic [4*BCD_DIGITS-1:0] dd_adjust(input logic [4*BCD_DIGITS-1:0] bcd);
        logic [4*BCD_DIGITS-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Nibble to active-low seven-segment glyph; the dash flag overrides the nibble.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (dash_i) begin
            seg_o = SEG_DASH;
        end else begin
            case (nibble_i)
                4'h0: seg_o = SEG_0;
                4'h1: seg_o = SEG_1;
                4'h2: seg_o = SEG_2;
                4'h3: seg_o = SEG_3;
                4'h4: seg_o = SEG_4;
                4'h5: seg_o = SEG_5;
                4'h6: seg_o = SEG_6;
                4'h7: seg_o = SEG_7;
                4'h8: seg_o = SEG_8;
                4'h9: seg_o = SEG_9;
                4'hA: seg_o = SEG_A;
                4'hB: seg_o = SEG_B;
                4'hC: seg_o = SEG_C;
                4'hD: seg_o = SEG_D;
                4'hE: seg_o = SEG_E;
                4'hF: seg_o = SEG_F;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed display of a captured 16-bit value, hex or decimal.
// Decimal goes through a sequential double-dabble; the display register only changes on commit.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_i,
    input  logic        load_i,
    input  logic        decimal_mode_i,
    output logic        busy_o,
    output logic        overflow_o,
    output logic [6:0]  segments_o,
    output logic [3:0]  anodes_o
);

    localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);

    generate
        if (NUM_DIGITS != 4) begin : g_bad_digits
            $error("seven_seg_scanner supports exactly 4 digits");
        end
    endgenerate

    // Scan path
    logic [CW-1:0] cnt_q;
    logic [1:0]    dig_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic [3:0]    nib_d;
    logic [6:0]    seg_d;

    // Display / conversion state
    state_t        state_q;
    logic          busy_q;
    logic          ovf_q;
    logic [15:0]   disp_q;
    logic          dash_q;
    logic [15:0]   bin_q;
    logic [19:0]   bcd_q;
    logic [19:0]   bcd_adj_d;
    logic [3:0]    iter_q;
    logic          pend_v_q;
    logic [15:0]   pend_val_q;
    logic          pend_dec_q;

    // Request serviced this cycle: live Load in IDLE, else the pending slot
    logic          svc_v;
    logic [15:0]   svc_val;
    logic          svc_dec;

    assign nib_d = disp_q[{dig_q, 2'b00} +: 4];

    seg_decoder u_dec (
        .nibble_i (nib_d),
        .dash_i   (dash_q),
        .seg_o    (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dig_q <= 2'd0;
            seg_q <= SEG_BLANK;
            an_q  <= 4'hF;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            dig_q <= dig_q + 2'd1;
            seg_q <= seg_d;
            an_q  <= ~(4'b0001 << dig_q);
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign bcd_adj_d = dd_adjust(bcd_q);

    always_comb begin
        svc_v   = 1'b0;
        svc_val = pend_val_q;
        svc_dec = pend_dec_q;
        if (state_q == ST_IDLE) begin
            if (load_i) begin
                svc_v   = 1'b1;
                svc_val = value_i;
                svc_dec = decimal_mode_i;
            end else begin
                svc_v   = pend_v_q;
            end
        end else if (state_q == ST_COMMIT) begin
            svc_v = pend_v_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= 16'h0000;
            dash_q     <= 1'b0;
            bin_q      <= 16'h0000;
            bcd_q      <= 20'h00000;
            iter_q     <= 4'd0;
            pend_v_q   <= 1'b0;
            pend_val_q <= 16'h0000;
            pend_dec_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_adj_d, bin_q} << 1;
                    iter_q         <= iter_q + 4'd1;
                    if (iter_q == 4'(BCD_ITER - 1))
                        state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (bcd_q[19:16] != 4'd0) begin
                        disp_q <= 16'hFFFF;
                        dash_q <= 1'b1;
                        ovf_q  <= 1'b1;
                    end else begin
                        disp_q <= bcd_q[15:0];
                        dash_q <= 1'b0;
                        ovf_q  <= 1'b0;
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Servicing overrides the commit defaults above, so a pending
            // decimal request chains with no Busy gap.
            if (svc_v) begin
                if (svc_dec) begin
                    bin_q   <= svc_val;
                    bcd_q   <= 20'h00000;
                    iter_q  <= 4'd0;
                    state_q <= ST_CONVERT;
                    busy_q  <= 1'b1;
                end else begin
                    disp_q  <= svc_val;
                    dash_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                end
            end

            if (state_q != ST_IDLE && load_i) begin
                pend_v_q   <= 1'b1;
                pend_val_q <= value_i;
                pend_dec_q <= decimal_mode_i;
            end else if (svc_v) begin
                pend_v_q   <= 1'b0;
            end
        end
    end

    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;
    assign segments_o = seg_q;
    assign anodes_o   = an_q;

endmodule
